// File: rtl/hazard_scoreboard.sv
// Hazard-detection / forwarding-select scoreboard: shift register of in-flight writes, youngest-match lookup per source.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cnt / fwd_cnt performance counters.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  localparam int FSEL_W    = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic                           issue_wr_en,
  input  logic                           issue_is_load,
  input  logic [REG_ADDR_W-1:0]          issue_rd,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr,
  input  logic                           flush,
  output logic                           stall,
  output logic [NUM_SRC*FSEL_W-1:0]      fwd_sel,
  output logic [CNT_W-1:0]               inflight
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    fwd_cnt
`endif
);

  logic [DEPTH-1:0]      slot_valid_q, slot_valid_d;
  logic [DEPTH-1:0]      slot_load_q, slot_load_d;
  logic [REG_ADDR_W-1:0] slot_rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] slot_rd_d [DEPTH];
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  stall_any;
  logic [NUM_SRC*FSEL_W-1:0] fwd_sel_c;
  logic                  insert;

  // Lookup reads only registered slots, so stall never depends on this cycle's insertion.
  always_comb begin
    stall_any = 1'b0;
    fwd_sel_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin : g_src
      logic hit;
      logic hit_load;
      int   hit_idx;
      int   ready;
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_idx  = 0;
      ready    = ALU_READY;
      // Scan oldest to youngest so the lowest-index (youngest) match is the one kept.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (slot_valid_q[i] && (slot_rd_q[i] == src_addr[s*REG_ADDR_W +: REG_ADDR_W])) begin
          hit      = 1'b1;
          hit_idx  = i;
          hit_load = slot_load_q[i];
        end
      end
      if (hit_load) ready = LOAD_READY;
      if (src_valid[s] && hit) begin
        if ((hit_idx + 1) < ready) begin
          stall_any = 1'b1;
        end else if ((hit_idx + 1) <= (DEPTH - 1)) begin
          fwd_sel_c[s*FSEL_W +: FSEL_W] = FSEL_W'(hit_idx + 1);
        end
      end
    end
  end

  assign stall   = issue_valid & ~flush & stall_any;
  assign fwd_sel = fwd_sel_c;
  assign insert  = issue_valid & issue_wr_en & ~stall & ~flush;

  always_comb begin
    slot_valid_d    = {slot_valid_q[DEPTH-2:0], insert};
    slot_load_d     = {slot_load_q[DEPTH-2:0], issue_is_load & insert};
    slot_rd_d[0]    = insert ? issue_rd : '0;
    for (int i = 1; i < DEPTH; i++) slot_rd_d[i] = slot_rd_q[i-1];
    inflight_d = '0;
    for (int i = 0; i < DEPTH; i++) inflight_d = inflight_d + CNT_W'(slot_valid_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_load_q  <= '0;
      inflight_q   <= '0;
      for (int i = 0; i < DEPTH; i++) slot_rd_q[i] <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_load_q  <= slot_load_d;
      inflight_q   <= inflight_d;
      for (int i = 0; i < DEPTH; i++) slot_rd_q[i] <= slot_rd_d[i];
    end
  end

  assign inflight = inflight_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (issue_valid && !stall && !flush && (|fwd_sel_c) && (fwd_cnt_q != 32'hFFFF_FFFF))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
